// File: rtl/counter_ctrl.sv
// Sequencing controller for a WIDTH-bit up/down counter with one-shot or
// auto-reload terminal handling under start/stop/load commands.
module counter_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stop,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             up_down,
    input  logic             mode,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HOLD = 2'b10,
        DONE = 2'b11
    } state_t;

    state_t           st_q;
    state_t           st_d;
    logic [WIDTH-1:0] count_d;
    logic             busy_d;
    logic             done_d;
    logic             at_term_c;
    logic [WIDTH-1:0] reload_c;

    // Terminal test and reload value both follow the current direction.
    assign at_term_c = up_down ? (count == limit) : (count == '0);
    assign reload_c  = up_down ? '0 : limit;

    // Next-state, next-count and pulse generation; load outranks every state.
    always_comb begin
        st_d    = st_q;
        count_d = count;
        done_d  = 1'b0;

        if (load) begin
            count_d = load_value;
            st_d    = IDLE;
        end else begin
            unique case (st_q)
                IDLE: begin
                    if (start && !stop) begin
                        st_d = RUN;
                    end
                end
                RUN: begin
                    if (stop) begin
                        st_d = HOLD;
                    end else if (at_term_c) begin
                        done_d = 1'b1;
                        if (mode) begin
                            count_d = reload_c;
                        end else begin
                            st_d = DONE;
                        end
                    end else if (up_down) begin
                        count_d = count + WIDTH'(1);
                    end else begin
                        count_d = count - WIDTH'(1);
                    end
                end
                HOLD: begin
                    if (start && !stop) begin
                        st_d = RUN;
                    end
                end
                DONE: begin
                    // stop has no effect once the count has finished
                    if (start) begin
                        st_d    = RUN;
                        count_d = reload_c;
                    end
                end
                default: st_d = IDLE;
            endcase
        end

        busy_d = (st_d == RUN) || (st_d == HOLD);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            st_q  <= IDLE;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            st_q  <= st_d;
            count <= count_d;
            busy  <= busy_d;
            done  <= done_d;
        end
    end

    assign state = st_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Self-checking bench for counter_ctrl: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a behavioural model.
module tb_counter_ctrl;

    localparam int unsigned WIDTH = 8;
    localparam int          MODV  = 1 << WIDTH;
    localparam int          S_IDLE = 0;
    localparam int          S_RUN  = 1;
    localparam int          S_HOLD = 2;
    localparam int          S_DONE = 3;

    logic             clock;
    logic             reset_n;
    logic             start;
    logic             stop;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             up_down;
    logic             mode;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;
    logic [1:0]       state;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: state name, count as plain integer, flags
    int m_state = S_IDLE;
    int m_count = 0;
    int m_busy  = 0;
    int m_done  = 0;

    counter_ctrl #(.WIDTH(WIDTH)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .stop       (stop),
        .load       (load),
        .load_value (load_value),
        .up_down    (up_down),
        .mode       (mode),
        .limit      (limit),
        .count      (count),
        .busy       (busy),
        .done       (done),
        .state      (state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic             rst_n;
        logic             st;
        logic             sp;
        logic             ld;
        logic [WIDTH-1:0] lv;
        logic             ud;
        logic             md;
        logic [WIDTH-1:0] lim;
        logic [WIDTH-1:0] e_count;
        logic [1:0]       e_state;
        logic             e_busy;
        logic             e_done;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Rules written directly from the command priorities and state meanings
    function automatic void model_step();
        int ns;
        int nc;
        int nd;
        bit term;
        ns = m_state;
        nc = m_count;
        nd = 0;
        if (!reset_n) begin
            ns = S_IDLE;
            nc = 0;
        end else if (load) begin
            nc = int'(load_value);
            ns = S_IDLE;
        end else if (m_state == S_IDLE || m_state == S_HOLD) begin
            if (start && !stop) ns = S_RUN;
        end else if (m_state == S_RUN) begin
            term = up_down ? (m_count == int'(limit)) : (m_count == 0);
            if (stop) ns = S_HOLD;
            else if (term) begin
                nd = 1;
                if (mode) nc = up_down ? 0 : int'(limit);
                else      ns = S_DONE;
            end else begin
                nc = (m_count + (up_down ? 1 : MODV - 1)) % MODV;
            end
        end else begin
            if (start) begin
                ns = S_RUN;
                nc = up_down ? 0 : int'(limit);
            end
        end
        m_state = ns;
        m_count = nc;
        m_done  = nd;
        m_busy  = (ns == S_RUN || ns == S_HOLD) ? 1 : 0;
    endfunction

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic drive(input logic r, input logic s, input logic p, input logic l,
                         input logic [WIDTH-1:0] v, input logic u, input logic m,
                         input logic [WIDTH-1:0] lm);
        reset_n    = r;
        start      = s;
        stop       = p;
        load       = l;
        load_value = v;
        up_down    = u;
        mode       = m;
        limit      = lm;
    endtask

    task automatic check_model();
        chk("rand_count", int'(count), m_count);
        chk("rand_state", int'(state), m_state);
        chk("rand_busy",  int'(busy),  m_busy);
        chk("rand_done",  int'(done),  m_done);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[27];
        int   e3c[8];
        int   e3d[8];
        int   e4c[10];
        int   e4s[10];
        int   e4d[10];
        int   e4p[10];

        drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, '0);

        // rst, start, stop, load, lv, ud, mode, limit -> count, state, busy, done
        tbl[0]  = '{1'b0,1'b1,1'b0,1'b1,8'hAA,1'b1,1'b1,8'h05, 8'h00,2'd0,1'b0,1'b0};
        tbl[1]  = '{1'b0,1'b0,1'b1,1'b0,8'h55,1'b0,1'b0,8'h03, 8'h00,2'd0,1'b0,1'b0};
        tbl[2]  = '{1'b1,1'b1,1'b0,1'b0,8'h00,1'b1,1'b0,8'h03, 8'h00,2'd1,1'b1,1'b0};
        tbl[3]  = '{1'b1,1'b0,1'b0,1'b0,8'h00,1'b1,1'b0,8'h03, 8'h01,2'd1,1'b1,1'b0};
        tbl[4]  = '{1'b1,1'b0,1'b0,1'b0,8'h00,1'b1,1'b0,8'h03, 8'h02,2'd1,1'b1,1'b0};
        tbl[5]  = '{1'b1,1'b0,1'b0,1'b0,8'h00,1'b1,1'b0,8'h03, 8'h03,2'd1,1'b1,1'b0};
        tbl[6]  = '{1'b1,1'b0,1'b0,1'b0,8'h00,1'b1,1'b0,8'h03, 8'h03,2'd3,1'b0,1'b1};
        tbl[7]  = '{1'b1,1'b0,1'b0,1'b0,8'h00,1'b1,1'b0,8'h03, 8'h03,2'd3,1'b0,1'b0};
        tbl[8]  = '{1'b1,1'b0,1'b0,1'b1,8'hFE,1'b1,1'b0,8'h01, 8'hFE,2'd0,1'b0,1'b0};
        tbl[9]  = '{1'b1,1'b1,1'b0,1'b0,8'hFE,1'b1,1'b0,8'h01, 8'hFE,2'd1,1'b1,1'b0};
        tbl[10] = '{1'b1,1'b0,1'b0,1'b0,8'hFE,1'b1,1'b0,8'h01, 8'hFF,2'd1,1'b1,1'b0};
        tbl[11] = '{1'b1,1'b0,1'b0,1'b0,8'hFE,1'b1,1'b0,8'h01, 8'h00,2'd1,1'b1,1'b0};
        tbl[12] = '{1'b1,1'b0,1'b0,1'b0,8'hFE,1'b1,1'b0,8'h01, 8'h01,2'd1,1'b1,1'b0};
        tbl[13] = '{1'b1,1'b0,1'b0,1'b0,8'hFE,1'b1,1'b0,8'h01, 8'h01,2'd3,1'b0,1'b1};
        tbl[14] = '{1'b1,1'b0,1'b0,1'b1,8'h07,1'b1,1'b0,8'h14, 8'h07,2'd0,1'b0,1'b0};
        tbl[15] = '{1'b1,1'b1,1'b0,1'b0,8'h07,1'b1,1'b0,8'h14, 8'h07,2'd1,1'b1,1'b0};
        tbl[16] = '{1'b0,1'b1,1'b0,1'b0,8'h07,1'b1,1'b0,8'h14, 8'h00,2'd0,1'b0,1'b0};
        tbl[17] = '{1'b1,1'b1,1'b0,1'b1,8'h09,1'b1,1'b0,8'h14, 8'h09,2'd0,1'b0,1'b0};
        tbl[18] = '{1'b1,1'b0,1'b0,1'b0,8'h09,1'b1,1'b0,8'h14, 8'h09,2'd0,1'b0,1'b0};
        tbl[19] = '{1'b1,1'b1,1'b1,1'b0,8'h09,1'b1,1'b0,8'h14, 8'h09,2'd0,1'b0,1'b0};
        tbl[20] = '{1'b1,1'b0,1'b0,1'b1,8'h00,1'b1,1'b0,8'h00, 8'h00,2'd0,1'b0,1'b0};
        tbl[21] = '{1'b1,1'b1,1'b0,1'b0,8'h00,1'b1,1'b0,8'h00, 8'h00,2'd1,1'b1,1'b0};
        tbl[22] = '{1'b1,1'b0,1'b0,1'b0,8'h00,1'b1,1'b0,8'h00, 8'h00,2'd3,1'b0,1'b1};
        tbl[23] = '{1'b1,1'b1,1'b1,1'b0,8'h00,1'b0,1'b0,8'h04, 8'h04,2'd1,1'b1,1'b0};
        tbl[24] = '{1'b1,1'b0,1'b0,1'b0,8'h00,1'b0,1'b0,8'h04, 8'h03,2'd1,1'b1,1'b0};
        tbl[25] = '{1'b1,1'b0,1'b0,1'b0,8'h00,1'b1,1'b0,8'h04, 8'h04,2'd1,1'b1,1'b0};
        tbl[26] = '{1'b1,1'b0,1'b0,1'b0,8'h00,1'b1,1'b1,8'h04, 8'h00,2'd1,1'b1,1'b1};

        #2;
        for (int i = 0; i < 27; i++) begin
            drive(tbl[i].rst_n, tbl[i].st, tbl[i].sp, tbl[i].ld,
                  tbl[i].lv, tbl[i].ud, tbl[i].md, tbl[i].lim);
            tick();
            chk($sformatf("vec%0d_count", i), int'(count), int'(tbl[i].e_count));
            chk($sformatf("vec%0d_state", i), int'(state), int'(tbl[i].e_state));
            chk($sformatf("vec%0d_busy",  i), int'(busy),  int'(tbl[i].e_busy));
            chk($sformatf("vec%0d_done",  i), int'(done),  int'(tbl[i].e_done));
        end

        // Auto-reload up to limit 2 with start held
        e3c = '{0, 1, 2, 0, 1, 2, 0, 1};
        e3d = '{0, 0, 0, 1, 0, 0, 1, 0};
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1, 8'd2);
        tick();
        reset_n = 1'b1;
        start   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("reload%0d_count", i), int'(count), e3c[i]);
            chk($sformatf("reload%0d_done",  i), int'(done),  e3d[i]);
            chk($sformatf("reload%0d_state", i), int'(state), S_RUN);
        end

        // Load 5, count down, pause at 3 for two cycles, finish at 0
        e4c = '{5, 4, 3, 3, 3, 3, 2, 1, 0, 0};
        e4s = '{1, 1, 1, 2, 2, 1, 1, 1, 1, 3};
        e4d = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        e4p = '{0, 0, 0, 1, 1, 0, 0, 0, 0, 0};
        drive(1'b1, 1'b0, 1'b0, 1'b1, 8'd5, 1'b0, 1'b0, 8'd9);
        tick();
        chk("down_load_count", int'(count), 5);
        chk("down_load_state", int'(state), S_IDLE);
        load  = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            stop = e4p[i][0];
            tick();
            chk($sformatf("down%0d_count", i), int'(count), e4c[i]);
            chk($sformatf("down%0d_state", i), int'(state), e4s[i]);
            chk($sformatf("down%0d_done",  i), int'(done),  e4d[i]);
        end
        start = 1'b0;

        // Randomized run against the model
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 8'd10);
        tick();
        check_model();
        for (int i = 0; i < 3000; i++) begin
            reset_n    = ($urandom_range(0, 149) != 0);
            load       = ($urandom_range(0, 24) == 0);
            start      = ($urandom_range(0, 2) == 0);
            stop       = ($urandom_range(0, 9) == 0);
            load_value = WIDTH'($urandom);
            if ($urandom_range(0, 9) == 0) up_down = ~up_down;
            if ($urandom_range(0, 19) == 0) mode = ~mode;
            if ($urandom_range(0, 29) == 0)
                limit = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 12));
            tick();
            check_model();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
